// File: rtl/store_size_ctrl.sv
// store_size_ctrl: sb/sh/sw sequencer for the multicycle MIPS datapath; sub-word stores read-modify-write.
// Optional STORE_ALIGN_CHECK_EN rejects misaligned sh/sw with an error pulse alongside done.
module store_size_ctrl #(
    parameter int unsigned RD_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  command,
    input  logic [31:0] addr,
    input  logic [31:0] rt_data,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        error
);
    typedef enum logic [2:0] {IDLE, RD, WAIT, WR, DONE} state_t;
    typedef enum logic [1:0] {
        CMD_SB  = 2'b00,
        CMD_SH  = 2'b01,
        CMD_SW  = 2'b10,
        CMD_RSV = 2'b11
    } cmd_t;

    state_t      state;
    cmd_t        cmd_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [31:0] buf_q;
    logic [31:0] merge_mask;
    logic [3:0]  cnt_q;
    logic        busy_q;
    logic        done_q;
    logic        error_q;
    logic        wr_q;
    logic        misaligned;

`ifdef STORE_ALIGN_CHECK_EN
    always_comb begin
        misaligned = 1'b0;
        if (cmd_t'(command) == CMD_SH)
            misaligned = addr[0];
        else if (cmd_t'(command) == CMD_SW)
            misaligned = |addr[1:0];
    end
`else
    assign misaligned = 1'b0;
`endif

    // Set bits select register data, clear bits keep the memory's existing bytes.
    always_comb begin
        merge_mask = (cmd_q == CMD_SB) ? 32'h0000_00FF : 32'h0000_FFFF;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cmd_q   <= CMD_SB;
            addr_q  <= '0;
            data_q  <= '0;
            buf_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            wr_q    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cmd_q  <= cmd_t'(command);
                        addr_q <= addr;
                        data_q <= rt_data;
                        busy_q <= 1'b1;
                        if (misaligned || cmd_t'(command) == CMD_RSV) begin
                            state   <= DONE;
                            done_q  <= 1'b1;
                            error_q <= misaligned;
                        end else if (cmd_t'(command) == CMD_SW) begin
                            state <= WR;
                            buf_q <= rt_data;
                            wr_q  <= 1'b1;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD: begin
                    cnt_q <= 4'(RD_LAT);
                    state <= WAIT;
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        buf_q <= (mem_rdata & ~merge_mask) | (data_q & merge_mask);
                        state <= WR;
                        wr_q  <= 1'b1;
                    end
                end
                WR: begin
                    state  <= DONE;
                    done_q <= 1'b1;
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wr    = wr_q;
    assign mem_wdata = buf_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_store_size_ctrl.sv
// Directed bench for store_size_ctrl: one instance with RD_LAT=1, one with RD_LAT=3.
// Read data is valid only on the capture edge; all other cycles carry a poison word.
module tb_store_size_ctrl;
    localparam logic [31:0] POISON = 32'hBAD0_0BAD;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_v;
    logic        sel;
    logic [1:0]  command;
    logic [31:0] addr;
    logic [31:0] rt_data;
    logic [31:0] rdata;

    logic        start1, start3;
    logic [31:0] addr1, wdata1, addr3, wdata3;
    logic        wr1, busy1, done1, err1;
    logic        wr3, busy3, done3, err3;

    logic [31:0] o_addr, o_wdata;
    logic        o_wr, o_busy, o_done, o_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign start1  = start_v & ~sel;
    assign start3  = start_v & sel;
    assign o_addr  = sel ? addr3  : addr1;
    assign o_wdata = sel ? wdata3 : wdata1;
    assign o_wr    = sel ? wr3    : wr1;
    assign o_busy  = sel ? busy3  : busy1;
    assign o_done  = sel ? done3  : done1;
    assign o_err   = sel ? err3   : err1;

    store_size_ctrl #(.RD_LAT(1)) u_dut1 (
        .clk       (clk),
        .reset     (reset),
        .start     (start1),
        .command   (command),
        .addr      (addr),
        .rt_data   (rt_data),
        .mem_rdata (rdata),
        .mem_addr  (addr1),
        .mem_wr    (wr1),
        .mem_wdata (wdata1),
        .busy      (busy1),
        .done      (done1),
        .error     (err1)
    );

    store_size_ctrl #(.RD_LAT(3)) u_dut3 (
        .clk       (clk),
        .reset     (reset),
        .start     (start3),
        .command   (command),
        .addr      (addr),
        .rt_data   (rt_data),
        .mem_rdata (rdata),
        .mem_addr  (addr3),
        .mem_wr    (wr3),
        .mem_wdata (wdata3),
        .busy      (busy3),
        .done      (done3),
        .error     (err3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Cycle c counts negedges after the start edge; done must appear in cycle exp_lat.
    task automatic run_op(input string name, input logic s, input logic [1:0] cmd,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] mem_word, input logic [31:0] exp_word,
                          input int exp_lat, input int exp_wr, input logic exp_err,
                          input logic disturb);
        int          c, lat, done_at, wr_cnt, wr_at, err_cnt, addr_bad, busy_gap;
        logic [31:0] wr_addr, wr_data, wdata_at_done;
        logic        err_at_done;
        lat = s ? 3 : 1;
        done_at = 0; wr_cnt = 0; wr_at = 0; err_cnt = 0; addr_bad = 0; busy_gap = 0;
        wr_addr = '0; wr_data = '0; wdata_at_done = '0; err_at_done = 1'b0;
        @(negedge clk);
        sel = s; command = cmd; addr = a; rt_data = d; rdata = POISON; start_v = 1'b1;
        c = 0;
        while (done_at == 0 && c < 40) begin
            @(negedge clk);
            c++;
            if (o_busy && o_addr !== a) addr_bad++;
            if (!o_busy) busy_gap++;
            if (o_wr) begin
                wr_cnt++; wr_at = c; wr_addr = o_addr; wr_data = o_wdata;
            end
            if (o_err) err_cnt++;
            if (o_done) begin
                done_at = c; err_at_done = o_err; wdata_at_done = o_wdata;
            end
            start_v = 1'b0;
            if (disturb && c == 2) begin
                start_v = 1'b1; command = 2'b10; addr = 32'h80; rt_data = '1;
            end
            rdata = (c == 1 + lat) ? mem_word : POISON;
        end
        check($sformatf("%s/done_cyc", name), done_at, exp_lat);
        check($sformatf("%s/wr_cnt", name), wr_cnt, exp_wr);
        if (exp_wr != 0) begin
            check($sformatf("%s/wr_cyc", name), wr_at, exp_lat - 1);
            check($sformatf("%s/wr_addr", name), wr_addr, a);
            check($sformatf("%s/wr_data", name), wr_data, exp_word);
            check($sformatf("%s/wdata_hold", name), wdata_at_done, exp_word);
        end
        check($sformatf("%s/err_at_done", name), {31'b0, err_at_done}, {31'b0, exp_err});
        check($sformatf("%s/err_cnt", name), err_cnt, {31'b0, exp_err});
        check($sformatf("%s/addr_bad", name), addr_bad, 0);
        check($sformatf("%s/busy_gap", name), busy_gap, 0);
        if (disturb) begin
            // start during the DONE cycle must be dropped
            start_v = 1'b1; command = 2'b10; addr = 32'h80; rt_data = '1;
        end
        @(negedge clk);
        check($sformatf("%s/post_ctl", name), {28'b0, o_wr, o_busy, o_done, o_err}, 32'h0);
        start_v = 1'b0;
    endtask

    initial begin
        int cnt;
        reset = 1'b0; start_v = 1'b0; sel = 1'b0; command = 2'b00;
        addr = '0; rt_data = '0; rdata = POISON;
        #1;
        check("rst1/addr", o_addr, 32'h0);
        check("rst1/wdata", o_wdata, 32'h0);
        check("rst1/ctl", {28'b0, o_wr, o_busy, o_done, o_err}, 32'h0);
        sel = 1'b1; #1;
        check("rst3/ctl", {28'b0, o_wr, o_busy, o_done, o_err}, 32'h0);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;

        run_op("sw",      1'b0, 2'b10, 32'h40, 32'hDEADBEEF, POISON,       32'hDEADBEEF, 2, 1, 1'b0, 1'b0);
        run_op("sb_l1",   1'b0, 2'b00, 32'h10, 32'hAABBCCDD, 32'h11223344, 32'h112233DD, 4, 1, 1'b0, 1'b0);
        run_op("sh_l3",   1'b1, 2'b01, 32'h20, 32'h0000BEEF, 32'h11223344, 32'h1122BEEF, 6, 1, 1'b0, 1'b0);
        run_op("sh_dist", 1'b1, 2'b01, 32'h24, 32'h1234CAFE, 32'hA5A55A5A, 32'hA5A5CAFE, 6, 1, 1'b0, 1'b1);
        run_op("sb_l3",   1'b1, 2'b00, 32'h28, 32'h00000077, 32'hCAFEF00D, 32'hCAFEF077, 6, 1, 1'b0, 1'b0);
        run_op("sw_l3",   1'b1, 2'b10, 32'h2C, 32'h01234567, POISON,       32'h01234567, 2, 1, 1'b0, 1'b0);
        run_op("rsv",     1'b0, 2'b11, 32'h40, 32'h99999999, POISON,       32'h0,        1, 0, 1'b0, 1'b0);
`ifdef STORE_ALIGN_CHECK_EN
        run_op("sh_mis",  1'b0, 2'b01, 32'h13, 32'h0000BEEF, 32'h11223344, 32'h0,        1, 0, 1'b1, 1'b0);
        run_op("sw_mis",  1'b0, 2'b10, 32'h42, 32'h01020304, POISON,       32'h0,        1, 0, 1'b1, 1'b0);
`else
        run_op("sh_odd",  1'b0, 2'b01, 32'h13, 32'h0000BEEF, 32'h11223344, 32'h1122BEEF, 4, 1, 1'b0, 1'b0);
        run_op("sw_odd",  1'b0, 2'b10, 32'h42, 32'h01020304, POISON,       32'h01020304, 2, 1, 1'b0, 1'b0);
`endif
        run_op("sb_odd",  1'b0, 2'b00, 32'h13, 32'hAABBCC5A, 32'h11223344, 32'h1122335A, 4, 1, 1'b0, 1'b0);

        // reset during WAIT on the RD_LAT=3 instance
        @(negedge clk);
        sel = 1'b1; command = 2'b01; addr = 32'h30; rt_data = 32'h00001234; start_v = 1'b1;
        @(negedge clk); start_v = 1'b0;
        @(negedge clk);
        check("rstw/busy_before", {31'b0, o_busy}, 32'h1);
        #1 reset = 1'b0;
        #1;
        check("rstw/addr", o_addr, 32'h0);
        check("rstw/wdata", o_wdata, 32'h0);
        check("rstw/ctl", {28'b0, o_wr, o_busy, o_done, o_err}, 32'h0);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (o_wr || o_done || o_busy) cnt++;
        end
        check("rstw/no_activity", cnt, 0);

        // reset while the write strobe is high
        @(negedge clk);
        sel = 1'b0; command = 2'b10; addr = 32'h50; rt_data = 32'h5555AAAA; start_v = 1'b1;
        @(negedge clk); start_v = 1'b0;
        check("rstwr/wr_before", {31'b0, o_wr}, 32'h1);
        #1 reset = 1'b0;
        #1;
        check("rstwr/ctl", {28'b0, o_wr, o_busy, o_done, o_err}, 32'h0);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (o_wr || o_done) cnt++;
        end
        check("rstwr/no_done", cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
